// File: rtl/mem_bus_arbiter_nexys3.sv
// Shared PSRAM/PCM bus arbiter for the Nexys3 memory pins.
// Two requesters (PSRAM side, PCM side) compete for one set of pins. The
// owner holds its request for a whole burst. Every change of owner inserts
// TURN_CYCLES idle bus cycles. An owner that keeps the bus for MAX_HOLD
// cycles while the other side waits is revoked. All pins come from registers.
module mem_bus_arbiter_nexys3 #(
  parameter int unsigned TURN_CYCLES = 2,   // idle cycles per owner change (1..15)
  parameter int unsigned MAX_HOLD    = 256  // 0 disables the hold limit
) (
  input  logic        clk,
  input  logic        rst_n,
  // PSRAM requester
  input  logic        ram_req,
  output logic        ram_grant,
  input  logic        ram_ce_i,
  input  logic        ram_oe_i,
  input  logic        ram_we_i,
  input  logic [22:0] ram_addr_i,
  input  logic [15:0] ram_dout_i,
  // PCM requester
  input  logic        pcm_req,
  output logic        pcm_grant,
  input  logic        pcm_ce_i,
  input  logic        pcm_oe_i,
  input  logic        pcm_we_i,
  input  logic [22:0] pcm_addr_i,
  input  logic [15:0] pcm_dout_i,
  // shared memory pins
  output logic        ram_ce_n,
  output logic        pcm_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic [22:0] mem_addr,
  output logic [15:0] mem_dout,
  input  logic [15:0] mem_din,
  output logic [15:0] ram_din,
  output logic [15:0] pcm_din
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_RAM = 2'd1,
    OWN_PCM = 2'd2,
    TURN    = 2'd3
  } state_t;

  // Hold counter only needs to reach MAX_HOLD; keep at least one bit.
  localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);

  state_t            state_q, state_d;
  logic              last_pcm_q, last_pcm_d;   // 1: PCM owned the bus last
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [3:0]        turn_q, turn_d;
  logic              ram_grant_q, ram_grant_d;
  logic              pcm_grant_q, pcm_grant_d;
  logic              ram_ce_n_q, ram_ce_n_d;
  logic              pcm_ce_n_q, pcm_ce_n_d;
  logic              mem_oe_n_q, mem_oe_n_d;
  logic              mem_we_n_q, mem_we_n_d;
  logic [22:0]       mem_addr_q, mem_addr_d;
  logic [15:0]       mem_dout_q, mem_dout_d;

  // Pick the next owner; on a tie the side that did not own the bus last wins.
  function automatic state_t arbitrate(input logic rq, input logic pq, input logic last_pcm);
    if (rq && pq) return last_pcm ? OWN_RAM : OWN_PCM;
    if (rq)       return OWN_RAM;
    if (pq)       return OWN_PCM;
    return IDLE;
  endfunction

  // Next-state, hold/turn counters and last-owner tracking.
  always_comb begin
    state_d    = state_q;
    last_pcm_d = last_pcm_q;
    hold_d     = hold_q;
    turn_d     = turn_q;
    case (state_q)
      IDLE: begin
        state_d = arbitrate(ram_req, pcm_req, last_pcm_q);
      end
      OWN_RAM: begin
        if (!ram_req) begin
          state_d = TURN;
        end else if (pcm_req) begin
          hold_d = hold_q + HOLD_W'(1);
          if ((MAX_HOLD != 0) && (hold_d == HOLD_LIMIT)) state_d = TURN;
        end
      end
      OWN_PCM: begin
        if (!pcm_req) begin
          state_d = TURN;
        end else if (ram_req) begin
          hold_d = hold_q + HOLD_W'(1);
          if ((MAX_HOLD != 0) && (hold_d == HOLD_LIMIT)) state_d = TURN;
        end
      end
      TURN: begin
        if (turn_q == TURN_LAST) begin
          turn_d  = 4'd0;
          state_d = arbitrate(ram_req, pcm_req, last_pcm_q);
        end else begin
          turn_d = turn_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A fresh ownership starts with a clean hold count and records its owner.
    if ((state_d != state_q) && ((state_d == OWN_RAM) || (state_d == OWN_PCM))) begin
      hold_d     = '0;
      last_pcm_d = (state_d == OWN_PCM);
    end
  end

  // Grants and pin values: a grant is held only while its OWN state persists,
  // and the pins follow the owner only while its grant stays high across the edge.
  always_comb begin
    ram_grant_d = (state_q == OWN_RAM) && (state_d == OWN_RAM);
    pcm_grant_d = (state_q == OWN_PCM) && (state_d == OWN_PCM);
    ram_ce_n_d  = 1'b1;
    pcm_ce_n_d  = 1'b1;
    mem_oe_n_d  = 1'b1;
    mem_we_n_d  = 1'b1;
    mem_addr_d  = mem_addr_q;
    mem_dout_d  = mem_dout_q;
    if (ram_grant_q && ram_grant_d) begin
      ram_ce_n_d = ~ram_ce_i;
      mem_oe_n_d = ~ram_oe_i;
      mem_we_n_d = ~(ram_we_i & ~ram_oe_i);  // never write while the device reads
      mem_addr_d = ram_addr_i;
      mem_dout_d = ram_dout_i;
    end else if (pcm_grant_q && pcm_grant_d) begin
      pcm_ce_n_d = ~pcm_ce_i;
      mem_oe_n_d = ~pcm_oe_i;
      mem_we_n_d = ~(pcm_we_i & ~pcm_oe_i);
      mem_addr_d = pcm_addr_i;
      mem_dout_d = pcm_dout_i;
    end
  end

  // All state and pin registers; reset forces an idle bus immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_pcm_q  <= 1'b1;
      hold_q      <= '0;
      turn_q      <= 4'd0;
      ram_grant_q <= 1'b0;
      pcm_grant_q <= 1'b0;
      ram_ce_n_q  <= 1'b1;
      pcm_ce_n_q  <= 1'b1;
      mem_oe_n_q  <= 1'b1;
      mem_we_n_q  <= 1'b1;
      mem_addr_q  <= '0;
      mem_dout_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_pcm_q  <= last_pcm_d;
      hold_q      <= hold_d;
      turn_q      <= turn_d;
      ram_grant_q <= ram_grant_d;
      pcm_grant_q <= pcm_grant_d;
      ram_ce_n_q  <= ram_ce_n_d;
      pcm_ce_n_q  <= pcm_ce_n_d;
      mem_oe_n_q  <= mem_oe_n_d;
      mem_we_n_q  <= mem_we_n_d;
      mem_addr_q  <= mem_addr_d;
      mem_dout_q  <= mem_dout_d;
    end
  end

  assign ram_grant = ram_grant_q;
  assign pcm_grant = pcm_grant_q;
  assign ram_ce_n  = ram_ce_n_q;
  assign pcm_ce_n  = pcm_ce_n_q;
  assign mem_oe_n  = mem_oe_n_q;
  assign mem_we_n  = mem_we_n_q;
  assign mem_addr  = mem_addr_q;
  assign mem_dout  = mem_dout_q;
  // Read data goes straight through; each owner samples it on its own timing.
  assign ram_din   = mem_din;
  assign pcm_din   = mem_din;

endmodule

// File: tb/tb_mem_bus_arbiter_nexys3.sv
`timescale 1ns/1ps
// Directed bench for mem_bus_arbiter_nexys3. Inputs change on the falling
// edge, outputs are checked on the falling edge (away from the rising edge).
module tb_mem_bus_arbiter_nexys3;

  localparam int unsigned TC = 2;
  localparam int unsigned MH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ram_req, ram_ce_i, ram_oe_i, ram_we_i;
  logic [22:0] ram_addr_i;
  logic [15:0] ram_dout_i;
  logic        pcm_req, pcm_ce_i, pcm_oe_i, pcm_we_i;
  logic [22:0] pcm_addr_i;
  logic [15:0] pcm_dout_i;
  logic        ram_grant, pcm_grant;
  logic        ram_ce_n, pcm_ce_n, mem_oe_n, mem_we_n;
  logic [22:0] mem_addr;
  logic [15:0] mem_dout, mem_din, ram_din, pcm_din;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter_nexys3 #(.TURN_CYCLES(TC), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n),
    .ram_req(ram_req), .ram_grant(ram_grant), .ram_ce_i(ram_ce_i),
    .ram_oe_i(ram_oe_i), .ram_we_i(ram_we_i), .ram_addr_i(ram_addr_i),
    .ram_dout_i(ram_dout_i),
    .pcm_req(pcm_req), .pcm_grant(pcm_grant), .pcm_ce_i(pcm_ce_i),
    .pcm_oe_i(pcm_oe_i), .pcm_we_i(pcm_we_i), .pcm_addr_i(pcm_addr_i),
    .pcm_dout_i(pcm_dout_i),
    .ram_ce_n(ram_ce_n), .pcm_ce_n(pcm_ce_n), .mem_oe_n(mem_oe_n),
    .mem_we_n(mem_we_n), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .ram_din(ram_din), .pcm_din(pcm_din)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_side_inputs();
    ram_ce_i = 0; ram_oe_i = 0; ram_we_i = 0; ram_addr_i = '0; ram_dout_i = '0;
    pcm_ce_i = 0; pcm_oe_i = 0; pcm_we_i = 0; pcm_addr_i = '0; pcm_dout_i = '0;
  endtask

  int   n;
  logic idle_ok;

  initial begin
    rst_n = 1'b1;
    ram_req = 0; pcm_req = 0;
    clear_side_inputs();
    mem_din = 16'hA5C3;
    #1 rst_n = 1'b0;
    #1;
    // reset state, before any clock edge
    chk("rst_ram_grant", ram_grant, 0);
    chk("rst_pcm_grant", pcm_grant, 0);
    chk("rst_ce_n", {ram_ce_n, pcm_ce_n}, 2'b11);
    chk("rst_oe_we_n", {mem_oe_n, mem_we_n}, 2'b11);
    chk("rst_addr", mem_addr, 0);
    chk("rst_dout", mem_dout, 0);
    chk("din_ram_copy", ram_din, 16'hA5C3);
    chk("din_pcm_copy", pcm_din, 16'hA5C3);
    mem_din = 16'h1234;
    #1;
    chk("din_ram_comb", ram_din, 16'h1234);
    rst_n = 1'b1;
    step(2);

    // Single requester write: request in cycle 0, grant visible after edge 2
    ram_req = 1;
    step(1);
    chk("single_grant_early", ram_grant, 0);
    step(1);
    chk("single_ram_grant", ram_grant, 1);
    chk("single_pcm_grant", pcm_grant, 0);
    ram_ce_i = 1; ram_we_i = 1; ram_addr_i = 23'h000123; ram_dout_i = 16'hBEEF;
    step(1);
    chk("write_ram_ce_n", ram_ce_n, 0);
    chk("write_we_n", mem_we_n, 0);
    chk("write_oe_n", mem_oe_n, 1);
    chk("write_addr", mem_addr, 23'h000123);
    chk("write_dout", mem_dout, 16'hBEEF);
    chk("write_pcm_ce_n", pcm_ce_n, 1);

    // Read and write enables together: reading wins, write held off
    ram_oe_i = 1;
    step(1);
    chk("guard_oe_n", mem_oe_n, 0);
    chk("guard_we_n", mem_we_n, 1);

    // Non-owner inputs toggle while PSRAM owns the bus
    pcm_ce_i = 1; pcm_we_i = 1; pcm_addr_i = 23'h7FFFFF; pcm_dout_i = 16'h1111;
    ram_oe_i = 0; ram_addr_i = 23'h000456; ram_dout_i = 16'h2222;
    step(1);
    chk("iso_pcm_ce_n", pcm_ce_n, 1);
    chk("iso_addr", mem_addr, 23'h000456);
    chk("iso_dout", mem_dout, 16'h2222);
    chk("iso_we_n", mem_we_n, 0);
    pcm_oe_i = 1; pcm_we_i = 0; pcm_addr_i = 23'h0ABCDE;
    step(1);
    chk("iso2_pcm_ce_n", pcm_ce_n, 1);
    chk("iso2_oe_n", mem_oe_n, 1);
    chk("iso2_addr", mem_addr, 23'h000456);

    // Release: pins go idle on the same edge, address and data hold
    ram_req = 0;
    clear_side_inputs();
    step(1);
    chk("rel_ram_grant", ram_grant, 0);
    chk("rel_pins_idle", {ram_ce_n, pcm_ce_n, mem_oe_n, mem_we_n}, 4'hF);
    step(3);
    chk("rel_addr_hold", mem_addr, 23'h000456);
    chk("rel_dout_hold", mem_dout, 16'h2222);
    chk("rel_no_grant", {ram_grant, pcm_grant}, 2'b00);

    // Tie straight after reset: PSRAM wins
    @(negedge clk); rst_n = 0; #2 rst_n = 1;
    step(1);
    ram_req = 1; pcm_req = 1;
    step(2);
    chk("tie1_ram_grant", ram_grant, 1);
    chk("tie1_pcm_grant", pcm_grant, 0);
    ram_req = 0;
    step(1);
    chk("tie1_ram_drop", ram_grant, 0);
    // TURN_CYCLES in TURN plus the registered-grant cycle, pins idle throughout
    n = 0; idle_ok = 1;
    while (pcm_grant !== 1'b1 && n < 20) begin
      step(1);
      n++;
      if (pcm_grant !== 1'b1 && {ram_ce_n, pcm_ce_n, mem_oe_n, mem_we_n} !== 4'hF) idle_ok = 0;
    end
    chk("tie1_gap_cycles", n, TC + 1);
    chk("tie1_gap_idle", idle_ok, 1);
    chk("tie1_pcm_grant", pcm_grant, 1);

    // Following tie: PCM releases, both request at arbitration, PSRAM again
    ram_req = 1; pcm_req = 0;
    step(1);
    chk("tie2_pcm_drop", pcm_grant, 0);
    pcm_req = 1;
    step(TC + 1);
    chk("tie2_ram_grant", ram_grant, 1);
    chk("tie2_pcm_grant", pcm_grant, 0);
    ram_req = 0; pcm_req = 0;
    step(6);

    // Hold limit: PSRAM keeps requesting while PCM waits
    ram_req = 1;
    step(2);
    chk("hold_ram_grant", ram_grant, 1);
    pcm_req = 1;
    n = 0;
    while (ram_grant === 1'b1 && n < 400) begin
      step(1);
      n++;
    end
    chk("hold_revoke_cycles", n, MH);
    n = 0;
    while (pcm_grant !== 1'b1 && n < 20) begin
      step(1);
      n++;
    end
    chk("hold_gap_cycles", n, TC + 1);
    chk("hold_ram_stays_off", ram_grant, 0);
    step(4);
    chk("hold_ram_still_off", ram_grant, 0);
    ram_req = 0; pcm_req = 0;
    step(6);

    // Asynchronous reset in the middle of a PCM write
    pcm_req = 1;
    step(2);
    chk("pcmw_grant", pcm_grant, 1);
    pcm_ce_i = 1; pcm_we_i = 1; pcm_addr_i = 23'h3C3C3C; pcm_dout_i = 16'hCAFE;
    step(1);
    chk("pcmw_ce_n", pcm_ce_n, 0);
    chk("pcmw_ram_ce_n", ram_ce_n, 1);
    chk("pcmw_we_n", mem_we_n, 0);
    chk("pcmw_addr", mem_addr, 23'h3C3C3C);
    #2 rst_n = 0;
    #1;
    chk("arst_pcm_ce_n", pcm_ce_n, 1);
    chk("arst_we_n", mem_we_n, 1);
    chk("arst_pcm_grant", pcm_grant, 0);
    chk("arst_addr", mem_addr, 0);
    rst_n = 1;
    ram_req = 1;
    step(1);
    chk("arst_tie_early", {ram_grant, pcm_grant}, 2'b00);
    step(1);
    chk("arst_tie_ram", ram_grant, 1);
    chk("arst_tie_pcm", pcm_grant, 0);
    chk("arst_tie_pcm_ce_n", pcm_ce_n, 1);
    ram_req = 0; pcm_req = 0;
    clear_side_inputs();
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
